// File: rtl/reg_file_sb.sv
// Multi-port register file with per-register busy scoreboard.
// Reads are combinational with same-cycle write bypass; x0 is hardwired to zero.
module reg_file_sb #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int NREAD = 2,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  write_enable,
   input  logic [AW-1:0]         rd_addr,
   input  logic [XLEN-1:0]       rd_data,
   input  logic [NREAD*AW-1:0]   rs_addr,
   output logic [NREAD*XLEN-1:0] rs_data,
   output logic [NREAD-1:0]      rs_busy,
   input  logic                  issue_valid,
   input  logic [AW-1:0]         issue_rd,
   output logic [AW:0]           busy_count
);

   localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

   logic [XLEN-1:0]  regs_q [NREGS];
   logic [XLEN-1:0]  regs_d [NREGS];
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;
   logic [AW:0]      cnt_q;
   logic [AW:0]      cnt_d;
   logic             ops_en_q;
   logic             ops_en_d;

   logic wr_ok;
   logic iss_ok;
   logic set_ev;
   logic clr_ev;

   // ops_en_q stays low for the first edge after reset release, so an
   // operation coincident with that edge is dropped.
   assign wr_ok  = ops_en_q && write_enable && (rd_addr != '0);
   assign iss_ok = ops_en_q && issue_valid && (issue_rd != '0);

   // A same-cycle issue to the written register keeps it reserved.
   assign set_ev = iss_ok && !busy_q[issue_rd];
   assign clr_ev = wr_ok && busy_q[rd_addr] && !(iss_ok && (issue_rd == rd_addr));

   always_comb begin
      regs_d   = regs_q;
      busy_d   = busy_q;
      cnt_d    = cnt_q;
      ops_en_d = 1'b1;
      if (wr_ok) begin
         regs_d[rd_addr] = rd_data;
         busy_d[rd_addr] = 1'b0;
      end
      if (iss_ok) begin
         busy_d[issue_rd] = 1'b1;
      end
      case ({set_ev, clr_ev})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
         busy_q   <= '0;
         cnt_q    <= '0;
         ops_en_q <= 1'b0;
      end else begin
         regs_q   <= regs_d;
         busy_q   <= busy_d;
         cnt_q    <= cnt_d;
         ops_en_q <= ops_en_d;
      end
   end

   assign busy_count = cnt_q;

   for (genvar k = 0; k < NREAD; k++) begin : g_rd
      logic [AW-1:0] rs_a;
      logic          wr_hit;
      logic          iss_hit;

      assign rs_a    = rs_addr[k*AW +: AW];
      assign wr_hit  = write_enable && (rd_addr != '0) && (rd_addr == rs_a);
      assign iss_hit = issue_valid && (issue_rd == rs_a);

      assign rs_data[k*XLEN +: XLEN] = (rs_a == '0) ? '0 :
                                       wr_hit        ? rd_data :
                                                       regs_q[rs_a];
      assign rs_busy[k] = (rs_a != '0) && busy_q[rs_a] && !(wr_hit && !iss_hit);
   end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: a default instance and a 64-bit/16-reg/4-port instance
// driven with identical stimulus and checked against a behavioural model.
module tb_reg_file_sb;

   logic clk;
   logic rst_n;

   logic        we_i;
   logic [3:0]  wa_i;
   logic [63:0] wd_i;
   logic [3:0]  ra_i [4];
   logic        iv_i;
   logic [3:0]  ir_i;

   logic [9:0]   rs_addr_a;
   logic [63:0]  rs_data_a;
   logic [1:0]   rs_busy_a;
   logic [5:0]   busy_count_a;

   logic [15:0]  rs_addr_b;
   logic [255:0] rs_data_b;
   logic [3:0]   rs_busy_b;
   logic [4:0]   busy_count_b;

   assign rs_addr_a = {1'b0, ra_i[1], 1'b0, ra_i[0]};
   assign rs_addr_b = {ra_i[3], ra_i[2], ra_i[1], ra_i[0]};

   reg_file_sb dut_a (
      .clk          (clk),
      .rst_n        (rst_n),
      .write_enable (we_i),
      .rd_addr      ({1'b0, wa_i}),
      .rd_data      (wd_i[31:0]),
      .rs_addr      (rs_addr_a),
      .rs_data      (rs_data_a),
      .rs_busy      (rs_busy_a),
      .issue_valid  (iv_i),
      .issue_rd     ({1'b0, ir_i}),
      .busy_count   (busy_count_a)
   );

   reg_file_sb #(.XLEN(64), .NREGS(16), .NREAD(4)) dut_b (
      .clk          (clk),
      .rst_n        (rst_n),
      .write_enable (we_i),
      .rd_addr      (wa_i),
      .rd_data      (wd_i),
      .rs_addr      (rs_addr_b),
      .rs_data      (rs_data_b),
      .rs_busy      (rs_busy_b),
      .issue_valid  (iv_i),
      .issue_rd     (ir_i),
      .busy_count   (busy_count_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [63:0] val;
   } sb_t;

   sb_t sb_q[$];

   int n_tests = 0;
   int n_fail  = 0;

   logic [63:0] m_regs [16];
   logic [15:0] m_busy;
   logic        m_en;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] exp_data(input logic [3:0] a);
      if (a == 4'd0) return 64'd0;
      if (we_i && (wa_i != 4'd0) && (wa_i == a)) return wd_i;
      return m_regs[a];
   endfunction

   function automatic logic exp_busy(input logic [3:0] a);
      if (a == 4'd0) return 1'b0;
      if (we_i && (wa_i == a) && !(iv_i && (ir_i == a))) return 1'b0;
      return m_busy[a];
   endfunction

   function automatic logic [63:0] exp_count();
      int c = 0;
      for (int i = 1; i < 16; i++) c += int'(m_busy[i]);
      return 64'(c);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_regs[i] = 64'd0;
      m_busy = 16'd0;
      m_en   = 1'b0;
   endtask

   task automatic model_step();
      if (!rst_n) begin
         m_en = 1'b0;
      end else begin
         if (m_en) begin
            if (we_i && wa_i != 4'd0) begin
               m_regs[wa_i] = wd_i;
               m_busy[wa_i] = 1'b0;
            end
            if (iv_i && ir_i != 4'd0) m_busy[ir_i] = 1'b1;
         end
         m_en = 1'b1;
      end
   endtask

   task automatic push_exp();
      for (int k = 0; k < 4; k++) begin
         sb_q.push_back('{$sformatf("b_data%0d", k), exp_data(ra_i[k])});
         sb_q.push_back('{$sformatf("b_busy%0d", k), 64'(exp_busy(ra_i[k]))});
      end
      for (int k = 0; k < 2; k++) begin
         sb_q.push_back('{$sformatf("a_data%0d", k), exp_data(ra_i[k]) & 64'hFFFF_FFFF});
         sb_q.push_back('{$sformatf("a_busy%0d", k), 64'(exp_busy(ra_i[k]))});
      end
      sb_q.push_back('{"b_cnt", exp_count()});
      sb_q.push_back('{"a_cnt", exp_count()});
   endtask

   task automatic pop_cmp(input logic [63:0] got);
      sb_t e;
      if (sb_q.size() == 0) begin
         check_val("sb_empty", 64'd1, 64'd0);
      end else begin
         e = sb_q.pop_front();
         check_val(e.tag, got, e.val);
      end
   endtask

   task automatic cmp_out();
      for (int k = 0; k < 4; k++) begin
         pop_cmp(rs_data_b[k*64 +: 64]);
         pop_cmp(64'(rs_busy_b[k]));
      end
      for (int k = 0; k < 2; k++) begin
         pop_cmp(64'(rs_data_a[k*32 +: 32]));
         pop_cmp(64'(rs_busy_a[k]));
      end
      pop_cmp(64'(busy_count_b));
      pop_cmp(64'(busy_count_a));
   endtask

   task automatic drive(input logic we, input logic [3:0] wa, input logic [63:0] wd,
                        input logic [3:0] r0, input logic [3:0] r1, input logic [3:0] r2,
                        input logic [3:0] r3, input logic iv, input logic [3:0] ir);
      we_i = we; wa_i = wa; wd_i = wd;
      ra_i[0] = r0; ra_i[1] = r1; ra_i[2] = r2; ra_i[3] = r3;
      iv_i = iv; ir_i = ir;
   endtask

   task automatic do_cycle(input logic we, input logic [3:0] wa, input logic [63:0] wd,
                           input logic [3:0] r0, input logic [3:0] r1, input logic [3:0] r2,
                           input logic [3:0] r3, input logic iv, input logic [3:0] ir);
      @(negedge clk);
      drive(we, wa, wd, r0, r1, r2, r3, iv, ir);
      push_exp();
      #2;
      cmp_out();
      @(posedge clk);
      model_step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 4'd0, 64'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0);
      model_reset();

      // Held in reset: everything reads zero, bypass still visible.
      do_cycle(1'b0, 4'd0, 64'd0, 4'd3, 4'd7, 4'd15, 4'd1, 1'b1, 4'd3);
      do_cycle(1'b1, 4'd6, 64'h0BAD_F00D_1234_5678, 4'd6, 4'd6, 4'd2, 4'd6, 1'b1, 4'd6);
      #2 rst_n = 1'b1;

      // First edge after release ignores write and issue.
      do_cycle(1'b1, 4'd1, 64'h77, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 4'd2);
      do_cycle(1'b0, 4'd0, 64'd0, 4'd1, 4'd2, 4'd1, 4'd2, 1'b0, 4'd0);

      // Sweep every address on every port.
      for (int i = 0; i < 16; i++) begin
         do_cycle(1'b0, 4'd0, 64'd0, 4'(i), 4'(i), 4'(i), 4'(i), 1'b0, 4'd0);
      end

      // Write x5 with bypass, then x0 ignored.
      do_cycle(1'b1, 4'd5, 64'h1234_5678_DEAD_BEEF, 4'd5, 4'd0, 4'd1, 4'd5, 1'b0, 4'd0);
      do_cycle(1'b0, 4'd0, 64'd0, 4'd5, 4'd5, 4'd5, 4'd5, 1'b0, 4'd0);
      do_cycle(1'b1, 4'd0, 64'h1, 4'd0, 4'd5, 4'd0, 4'd0, 1'b0, 4'd0);
      do_cycle(1'b0, 4'd0, 64'd0, 4'd0, 4'd0, 4'd5, 4'd0, 1'b0, 4'd0);

      // Issue x3, x7, then write x3 clears it.
      do_cycle(1'b0, 4'd0, 64'd0, 4'd3, 4'd7, 4'd3, 4'd7, 1'b1, 4'd3);
      do_cycle(1'b0, 4'd0, 64'd0, 4'd3, 4'd7, 4'd3, 4'd7, 1'b1, 4'd7);
      do_cycle(1'b1, 4'd3, 64'h33, 4'd3, 4'd7, 4'd3, 4'd7, 1'b0, 4'd0);
      do_cycle(1'b0, 4'd0, 64'd0, 4'd3, 4'd7, 4'd3, 4'd7, 1'b0, 4'd0);

      // Issue and write x9 together: data lands, reservation wins.
      do_cycle(1'b1, 4'd9, 64'h55, 4'd9, 4'd7, 4'd9, 4'd3, 1'b1, 4'd9);
      do_cycle(1'b0, 4'd0, 64'd0, 4'd9, 4'd7, 4'd9, 4'd3, 1'b0, 4'd0);

      // Re-issue busy x7, write non-busy x12, issue x0, mixed issue/clear.
      do_cycle(1'b1, 4'd12, 64'hC0FFEE, 4'd7, 4'd12, 4'd9, 4'd12, 1'b1, 4'd7);
      do_cycle(1'b0, 4'd0, 64'd0, 4'd7, 4'd12, 4'd0, 4'd12, 1'b1, 4'd0);
      do_cycle(1'b1, 4'd7, 64'h7777, 4'd7, 4'd11, 4'd7, 4'd11, 1'b1, 4'd11);
      do_cycle(1'b0, 4'd0, 64'd0, 4'd7, 4'd11, 4'd9, 4'd12, 1'b0, 4'd0);

      for (int i = 0; i < 40; i++) begin
         do_cycle(1'($urandom), 4'($urandom_range(0, 15)), {$urandom, $urandom},
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom), 4'($urandom_range(0, 15)));
      end

      // Mid-cycle reset wipes data and reservations before the next edge.
      do_cycle(1'b0, 4'd0, 64'd0, 4'd4, 4'd10, 4'd0, 4'd0, 1'b1, 4'd4);
      do_cycle(1'b1, 4'd10, 64'hA, 4'd4, 4'd10, 4'd5, 4'd9, 1'b0, 4'd0);
      #3;
      rst_n = 1'b0;
      model_reset();
      drive(1'b0, 4'd0, 64'd0, 4'd10, 4'd4, 4'd5, 4'd9, 1'b0, 4'd0);
      push_exp();
      #1;
      cmp_out();
      @(posedge clk);
      #2 rst_n = 1'b1;
      do_cycle(1'b1, 4'd2, 64'h99, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 4'd8);
      do_cycle(1'b0, 4'd0, 64'd0, 4'd2, 4'd8, 4'd10, 4'd4, 1'b0, 4'd0);
      do_cycle(1'b1, 4'd2, 64'h99, 4'd2, 4'd8, 4'd0, 4'd0, 1'b1, 4'd8);
      do_cycle(1'b0, 4'd0, 64'd0, 4'd2, 4'd8, 4'd10, 4'd4, 1'b0, 4'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data word width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count; power of two, 2..64.
REQ-003 SHALL have parameter NREAD, default 2, read-port count, 1..4.
REQ-004 SHALL have derived localparam AW = clog2(NREGS), address width.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset; asynchronous, active-low.
REQ-007 write_enable  input  1  commit write of rd_data to rd_addr.
REQ-008 rd_addr  input  AW  write address.
REQ-009 rd_data  input  XLEN  write data.
REQ-010 rs_addr  input  NREAD*AW  read addresses; port k at bits [k*AW +: AW].
REQ-011 rs_data  output  NREAD*XLEN  read data; port k at bits [k*XLEN +: XLEN].
REQ-012 rs_busy  output  NREAD  port k register has an outstanding write.
REQ-013 issue_valid  input  1  reserve destination issue_rd (mark busy).
REQ-014 issue_rd  input  AW  destination being reserved.
REQ-015 busy_count  output  AW+1  number of registers currently busy.

Function
REQ-016 Register 0 SHALL read as 0 at all times; writes and issues to address 0 SHALL be ignored.
REQ-017 write_enable=1 with rd_addr!=0 SHALL update the register on the next rising clk.
REQ-018 rs_data port k SHALL be combinational: register content, except when write_enable=1, rd_addr!=0 and rd_addr==rs_addr[k], in which case it SHALL return rd_data (same-cycle bypass).
REQ-019 Every read port SHALL be independent; any number of ports MAY read the same address.
REQ-020 Each register SHALL have a busy bit; issue_valid=1 with issue_rd!=0 SHALL set it at the next edge.
REQ-021 write_enable=1 with rd_addr!=0 SHALL clear that register's busy bit at the next edge.
REQ-022 Simultaneous issue and write to the same non-zero address SHALL leave busy set (new reservation wins).
REQ-023 Issue to an already-busy register SHALL keep it busy; no error, no count change.
REQ-024 Write to a non-busy register SHALL update data and leave busy clear.
REQ-025 rs_busy[k] SHALL be combinational from the busy bits, 0 for address 0, and 0 when the same cycle's write clears that register unless REQ-022 applies.
REQ-026 busy_count SHALL be a registered count of set busy bits, updated in the same edge as the bits; +1, -1, or unchanged per cycle; never exceeds NREGS-1.
REQ-027 Reads and writes to addresses >= NREGS cannot occur (AW exact); no range check SHALL be added.

Reset
REQ-028 rst_n=0 SHALL immediately clear all registers to 0, all busy bits to 0, busy_count to 0, independent of clk.
REQ-029 During reset rs_data SHALL be 0 for all ports except when a same-cycle bypass applies; rs_busy SHALL be 0.
REQ-030 A write or issue coincident with the edge on which rst_n deasserts SHALL be ignored; the first accepted operation is on the following edge.
REQ-031 Asserting rst_n mid-operation SHALL discard all reservations and data; no partial update SHALL survive.

Verification
REQ-032 Reset, then read all addresses on every port -> all rs_data 0, rs_busy 0, busy_count 0.
REQ-033 Write x5=0xDEADBEEF while port0 reads x5 -> port0 shows 0xDEADBEEF same cycle; next cycle still 0xDEADBEEF; write x0=0x1 -> x0 reads 0.
REQ-034 Issue x3, x7 on consecutive cycles -> busy_count 1 then 2, rs_busy set on ports reading x3/x7; write x3 -> busy_count 1, x3 not busy.
REQ-035 Same cycle issue x9 and write x9=0x55 -> x9 reads 0x55, remains busy, busy_count +1.
REQ-036 Issue x4, write x10=0xA, then pulse rst_n low between edges -> all data 0, busy_count 0 immediately, before next clk.
REQ-037 Rerun REQ-033/034 with XLEN=64, NREGS=16, NREAD=4 -> identical behaviour; busy_count width 5.
